rtc_i2c_target: RTL

//  I2C responder (target) emulating a DS-style battery RTC register file; the far end of the
//  I2C link driven by rtc_controller. Used on-board as a soft RTC when no RTC chip is fitted,
//  and as the bus partner in rtc_controller benches. Sits on clk14 beside rtc_emulation.

---
 rtl/rtc_i2c_target.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/rtc_i2c_target.sv
// I2C target emulating a DS-style RTC register file, with a local host port.
// The bus is oversampled on clk14; SDA is only changed on synchronised SCL falling edges.
module rtc_i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h68,
  parameter int         PTR_W    = 3
) (
  input  logic             clk14,
  input  logic             reset_n,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_o,
  output logic             sda_oen,
  input  logic             host_we,
  input  logic [PTR_W-1:0] host_addr,
  input  logic [7:0]       host_wdata,
  output logic [7:0]       host_rdata,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy
);

  localparam int NREG = 1 << PTR_W;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK
  } state_t;

  state_t           r_state, w_nextState;
  logic [1:0]       r_sclSync, r_sdaSync;
  logic             r_sclPrev, r_sdaPrev;
  logic [3:0]       r_bitCnt;
  logic [7:0]       r_shift;
  logic             r_ackBit;
  logic [PTR_W-1:0] r_ptr;
  logic             r_sdaOen, r_busy, r_wrStrobe;
  logic [PTR_W-1:0] r_wrAddr;
  logic [7:0]       r_wrData;
  logic [7:0]       r_regs [NREG];

  logic w_scl, w_sda, w_sclRise, w_sclFall, w_start, w_stop;
  logic w_cnt8, w_addrMatch, w_rxState, w_cntState;
  logic w_oenNext, w_busyNext, w_commit, w_ptrLoad, w_ptrInc, w_loadRead, w_shiftOut;

  // Bus idles high, so the synchronisers reset to 1 to avoid a phantom edge.
  always_ff @(posedge clk14 or negedge reset_n) begin
    if (!reset_n) begin
      r_sclSync <= 2'b11;
      r_sdaSync <= 2'b11;
      r_sclPrev <= 1'b1;
      r_sdaPrev <= 1'b1;
    end else begin
      r_sclSync <= {r_sclSync[0], scl_i};
      r_sdaSync <= {r_sdaSync[0], sda_i};
      r_sclPrev <= r_sclSync[1];
      r_sdaPrev <= r_sdaSync[1];
    end
  end

  assign w_scl       = r_sclSync[1];
  assign w_sda       = r_sdaSync[1];
  assign w_sclRise   = !r_sclPrev && w_scl;
  assign w_sclFall   = r_sclPrev && !w_scl;
  assign w_start     = r_sclPrev && w_scl && r_sdaPrev && !w_sda;
  assign w_stop      = r_sclPrev && w_scl && !r_sdaPrev && w_sda;
  assign w_cnt8      = (r_bitCnt == 4'd8);
  assign w_addrMatch = (r_shift[7:1] == DEV_ADDR);
  assign w_rxState   = (r_state == S_ADDR) || (r_state == S_PTR) || (r_state == S_WDATA);
  assign w_cntState  = w_rxState || (r_state == S_RDATA);

  always_ff @(posedge clk14 or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (w_start) w_nextState = S_ADDR;
    else if (w_stop) w_nextState = S_IDLE;
    else if (w_sclFall) begin
      case (r_state)
        S_ADDR:      if (w_cnt8) w_nextState = w_addrMatch ? S_ADDR_ACK : S_IDLE;
        S_ADDR_ACK:  w_nextState = r_shift[0] ? S_RDATA : S_PTR;
        S_PTR:       if (w_cnt8) w_nextState = S_PTR_ACK;
        S_PTR_ACK:   w_nextState = S_WDATA;
        S_WDATA:     if (w_cnt8) w_nextState = S_WDATA_ACK;
        S_WDATA_ACK: w_nextState = S_WDATA;
        S_RDATA:     if (w_cnt8) w_nextState = S_RDATA_ACK;
        S_RDATA_ACK: w_nextState = r_ackBit ? S_IDLE : S_RDATA;
        default:     w_nextState = S_IDLE;
      endcase
    end
  end

  // A fall ending an ACK phase both releases SDA and, for reads, presents the next MSB.
  always_comb begin
    w_oenNext  = r_sdaOen;
    w_busyNext = r_busy;
    w_commit   = 1'b0;
    w_ptrLoad  = 1'b0;
    w_ptrInc   = 1'b0;
    w_loadRead = 1'b0;
    w_shiftOut = 1'b0;
    if (w_start || w_stop) begin
      w_oenNext  = 1'b1;
      w_busyNext = 1'b0;
    end else if (w_sclFall) begin
      case (r_state)
        S_ADDR: if (w_cnt8 && w_addrMatch) begin
          w_oenNext  = 1'b0;
          w_busyNext = 1'b1;
        end
        S_ADDR_ACK: if (r_shift[0]) begin
          w_loadRead = 1'b1;
          w_oenNext  = r_regs[r_ptr][7];
        end else w_oenNext = 1'b1;
        S_PTR, S_WDATA: if (w_cnt8) w_oenNext = 1'b0;
        S_PTR_ACK: begin
          w_ptrLoad = 1'b1;
          w_oenNext = 1'b1;
        end
        S_WDATA_ACK: begin
          w_commit  = 1'b1;
          w_ptrInc  = 1'b1;
          w_oenNext = 1'b1;
        end
        S_RDATA: if (w_cnt8) begin
          w_oenNext = 1'b1;
          w_ptrInc  = 1'b1;
        end else begin
          w_shiftOut = 1'b1;
          w_oenNext  = r_shift[6];
        end
        S_RDATA_ACK: if (r_ackBit) begin
          w_oenNext  = 1'b1;
          w_busyNext = 1'b0;
        end else begin
          w_loadRead = 1'b1;
          w_oenNext  = r_regs[r_ptr][7];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk14 or negedge reset_n) begin
    if (!reset_n) begin
      r_bitCnt   <= '0;
      r_shift    <= '0;
      r_ackBit   <= 1'b1;
      r_ptr      <= '0;
      r_sdaOen   <= 1'b1;
      r_busy     <= 1'b0;
      r_wrStrobe <= 1'b0;
      r_wrAddr   <= '0;
      r_wrData   <= '0;
    end else begin
      if (w_start || (w_nextState != r_state)) r_bitCnt <= '0;
      else if (w_sclRise && w_cntState)        r_bitCnt <= r_bitCnt + 4'd1;
      if (w_loadRead)                  r_shift <= r_regs[r_ptr];
      else if (w_shiftOut)             r_shift <= {r_shift[6:0], 1'b0};
      else if (w_sclRise && w_rxState) r_shift <= {r_shift[6:0], w_sda};
      if (w_sclRise && (r_state == S_RDATA_ACK)) r_ackBit <= w_sda;
      if (w_ptrLoad)     r_ptr <= r_shift[PTR_W-1:0];
      else if (w_ptrInc) r_ptr <= r_ptr + PTR_W'(1);
      r_sdaOen   <= w_oenNext;
      r_busy     <= w_busyNext;
      r_wrStrobe <= w_commit;
      if (w_commit) begin
        r_wrAddr <= r_ptr;
        r_wrData <= r_shift;
      end
    end
  end

  // The I2C commit is placed last so it overrides a same-cycle host write to that register.
  always_ff @(posedge clk14 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      if (host_we) r_regs[host_addr] <= host_wdata;
      if (w_commit) r_regs[r_ptr] <= r_shift;
    end
  end

  assign sda_o      = 1'b0;
  assign sda_oen    = r_sdaOen;
  assign busy       = r_busy;
  assign wr_strobe  = r_wrStrobe;
  assign wr_addr    = r_wrAddr;
  assign wr_data    = r_wrData;
  assign host_rdata = r_regs[host_addr];

endmodule
